// File: rtl/cr_had_pkg.sv
// rtl/cr_had_pkg.sv - shared types and constants for the HAD breakpoint controller
package cr_had_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HALT_REQ,
      ST_BKPT_REQ,
      ST_DEBUG,
      ST_STEP
   } had_state_e;

   localparam logic ACT_DBG = 1'b0;
   localparam logic ACT_EXP = 1'b1;

   // Opcode the IFU substitutes for a matched fetch
   localparam logic [31:0] EBREAK = 32'h00100073;

endpackage

// File: rtl/cr_had_bkpt_cmp.sv
// rtl/cr_had_bkpt_cmp.sv - one PC comparator with its config registers
// Optional masked compare under HAD_BKPT_MASK_EN.
module cr_had_bkpt_cmp
   import cr_had_pkg::*;
#(
   parameter int PC_WIDTH = 32,
   parameter int IDXW     = 1,
   parameter int IDX      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_wr_vld,
   input  logic [IDXW-1:0]       cfg_wr_idx,
   input  logic [PC_WIDTH-1:1]   cfg_wr_addr,
   input  logic                  cfg_wr_en,
   input  logic                  cfg_wr_exp,
`ifdef HAD_BKPT_MASK_EN
   input  logic [PC_WIDTH-1:1]   cfg_wr_mask,
`endif
   input  logic                  match_vld,
   input  logic [PC_WIDTH-1:1]   fetch_addr,
   output logic                  hit,
   output logic                  exp_act
);

   logic [PC_WIDTH-1:1] addr_q;
   logic                en_q;
   logic                exp_q;
   logic                sel;
   logic                addr_eq;

   assign sel = cfg_wr_vld && (cfg_wr_idx == IDXW'(IDX));

`ifdef HAD_BKPT_MASK_EN
   logic [PC_WIDTH-1:1] mask_q;

   always_ff @(posedge clk) begin
      if (rst)      mask_q <= '0;
      else if (sel) mask_q <= cfg_wr_mask;
   end

   assign addr_eq = (((fetch_addr ^ addr_q) & ~mask_q) == '0);
`else
   assign addr_eq = (fetch_addr == addr_q);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q <= '0;
         en_q   <= 1'b0;
         exp_q  <= ACT_DBG;
      end else if (sel) begin
         addr_q <= cfg_wr_addr;
         en_q   <= cfg_wr_en;
         exp_q  <= cfg_wr_exp;
      end
   end

   assign hit     = match_vld & en_q & addr_eq;
   assign exp_act = exp_q;

endmodule

// File: rtl/cr_had_bkpt_ctrl.sv
// rtl/cr_had_bkpt_ctrl.sv - HAD breakpoint/halt request controller (top)
// Define HAD_BKPT_MASK_EN for per-comparator address masks.
module cr_had_bkpt_ctrl
   import cr_had_pkg::*;
#(
   parameter  int BKPT_NUM = 2,
   parameter  int PC_WIDTH = 32,
   localparam int IDXW     = (BKPT_NUM > 1) ? $clog2(BKPT_NUM) : 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst,
   input  logic                  dbg_halt_req,
   input  logic                  dbg_resume_req,
   input  logic                  cfg_wr_vld,
   input  logic [IDXW-1:0]       cfg_wr_idx,
   input  logic [PC_WIDTH-1:1]   cfg_wr_addr,
   input  logic                  cfg_wr_en,
   input  logic                  cfg_wr_exp,
`ifdef HAD_BKPT_MASK_EN
   input  logic [PC_WIDTH-1:1]   cfg_wr_mask,
`endif
   input  logic                  cfg_step_en,
   input  logic                  cfg_mbee,
   input  logic                  ifu_had_fetch_vld,
   input  logic [PC_WIDTH-1:0]   ifu_had_fetch_pc,
   input  logic                  ifu_had_inst_dbg_disable,
   input  logic                  iu_had_bkpt_ack,
   input  logic                  iu_had_retire_vld,
   output logic                  had_core_dbg_mode_req,
   output logic                  had_ifu_inst_bkpt_dbq_req,
   output logic                  had_ifu_inst_bkpt_dbqexp_req,
   output logic                  had_yy_xx_dp_index_mbee,
   output logic                  had_dbg_mode,
   output logic                  had_bkpt_hit_vld,
   output logic [IDXW-1:0]       had_bkpt_hit_idx
);

   had_state_e          state, state_nxt;
   logic [BKPT_NUM-1:0] hit;
   logic [BKPT_NUM-1:0] exp_act;
   logic                match_vld;
   logic                any_hit;
   logic [IDXW-1:0]     hit_idx_c;
   logic                hit_exp_c;
   logic                act_q, act_nxt;
   logic                take_bkpt;
   logic                clr_hit;
   logic                unused_pc0;

   // Halfword-aligned fetch: bit 0 never takes part in the compare
   assign unused_pc0 = ifu_had_fetch_pc[0];
   assign match_vld  = ifu_had_fetch_vld & ~ifu_had_inst_dbg_disable;

   for (genvar g = 0; g < BKPT_NUM; g++) begin : g_cmp
      cr_had_bkpt_cmp #(
         .PC_WIDTH (PC_WIDTH),
         .IDXW     (IDXW),
         .IDX      (g)
      ) u_cmp (
         .clk         (forever_cpuclk),
         .rst         (cpurst),
         .cfg_wr_vld  (cfg_wr_vld),
         .cfg_wr_idx  (cfg_wr_idx),
         .cfg_wr_addr (cfg_wr_addr),
         .cfg_wr_en   (cfg_wr_en),
         .cfg_wr_exp  (cfg_wr_exp),
`ifdef HAD_BKPT_MASK_EN
         .cfg_wr_mask (cfg_wr_mask),
`endif
         .match_vld   (match_vld),
         .fetch_addr  (ifu_had_fetch_pc[PC_WIDTH-1:1]),
         .hit         (hit[g]),
         .exp_act     (exp_act[g])
      );
   end

   // Scan downwards so the lowest matching index is the one left standing
   always_comb begin
      any_hit   = 1'b0;
      hit_idx_c = '0;
      hit_exp_c = ACT_DBG;
      for (int i = BKPT_NUM - 1; i >= 0; i--) begin
         if (hit[i]) begin
            any_hit   = 1'b1;
            hit_idx_c = IDXW'(i);
            hit_exp_c = exp_act[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      take_bkpt = 1'b0;
      clr_hit   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dbg_halt_req) begin
               state_nxt = ST_HALT_REQ;
            end else if (any_hit) begin
               state_nxt = ST_BKPT_REQ;
               take_bkpt = 1'b1;
            end
         end
         ST_HALT_REQ: begin
            if (iu_had_bkpt_ack) state_nxt = ST_DEBUG;
         end
         ST_BKPT_REQ: begin
            if (iu_had_bkpt_ack) state_nxt = (act_q == ACT_EXP) ? ST_IDLE : ST_DEBUG;
         end
         ST_DEBUG: begin
            if (dbg_resume_req) begin
               if (cfg_step_en) begin
                  state_nxt = ST_STEP;
               end else begin
                  state_nxt = ST_IDLE;
                  clr_hit   = 1'b1;
               end
            end
         end
         ST_STEP: begin
            if (iu_had_retire_vld) state_nxt = ST_HALT_REQ;
         end
         default: state_nxt = ST_IDLE;
      endcase
      act_nxt = take_bkpt ? hit_exp_c : act_q;
   end

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state                        <= ST_IDLE;
         act_q                        <= ACT_DBG;
         had_core_dbg_mode_req        <= 1'b0;
         had_ifu_inst_bkpt_dbq_req    <= 1'b0;
         had_ifu_inst_bkpt_dbqexp_req <= 1'b0;
         had_yy_xx_dp_index_mbee      <= 1'b0;
         had_dbg_mode                 <= 1'b0;
         had_bkpt_hit_vld             <= 1'b0;
         had_bkpt_hit_idx             <= '0;
      end else begin
         state                        <= state_nxt;
         act_q                        <= act_nxt;
         had_core_dbg_mode_req        <= (state_nxt == ST_HALT_REQ);
         had_ifu_inst_bkpt_dbq_req    <= (state_nxt == ST_BKPT_REQ) && (act_nxt == ACT_DBG);
         had_ifu_inst_bkpt_dbqexp_req <= (state_nxt == ST_BKPT_REQ) && (act_nxt == ACT_EXP);
         had_yy_xx_dp_index_mbee      <= cfg_mbee;
         had_dbg_mode                 <= (state_nxt == ST_DEBUG);
         if (take_bkpt) begin
            had_bkpt_hit_vld <= 1'b1;
            had_bkpt_hit_idx <= hit_idx_c;
         end else if (clr_hit) begin
            had_bkpt_hit_vld <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cr_had_bkpt_ctrl.sv
// tb/tb_cr_had_bkpt_ctrl.sv - directed bench for cr_had_bkpt_ctrl
// Output vector order: {core_req, dbq_req, dbqexp_req, dbg_mode, hit_vld, hit_idx}.
module tb_cr_had_bkpt_ctrl;

   logic        clk = 1'b0;
   logic        cpurst = 1'b1;
   logic        dbg_halt_req = 1'b0;
   logic        dbg_resume_req = 1'b0;
   logic        cfg_wr_vld = 1'b0;
   logic [0:0]  cfg_wr_idx = '0;
   logic [31:1] cfg_wr_addr = '0;
   logic        cfg_wr_en = 1'b0;
   logic        cfg_wr_exp = 1'b0;
`ifdef HAD_BKPT_MASK_EN
   logic [31:1] cfg_wr_mask = '0;
`endif
   logic        cfg_step_en = 1'b0;
   logic        cfg_mbee = 1'b0;
   logic        fetch_vld = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        dbg_disable = 1'b0;
   logic        ack = 1'b0;
   logic        retire = 1'b0;
   logic        core_req, dbq_req, dbqexp_req, mbee, dbg_mode, hit_vld;
   logic [0:0]  hit_idx;
   logic [5:0]  outs;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cr_had_bkpt_ctrl #(.BKPT_NUM(2), .PC_WIDTH(32)) dut (
      .forever_cpuclk               (clk),
      .cpurst                       (cpurst),
      .dbg_halt_req                 (dbg_halt_req),
      .dbg_resume_req               (dbg_resume_req),
      .cfg_wr_vld                   (cfg_wr_vld),
      .cfg_wr_idx                   (cfg_wr_idx),
      .cfg_wr_addr                  (cfg_wr_addr),
      .cfg_wr_en                    (cfg_wr_en),
      .cfg_wr_exp                   (cfg_wr_exp),
`ifdef HAD_BKPT_MASK_EN
      .cfg_wr_mask                  (cfg_wr_mask),
`endif
      .cfg_step_en                  (cfg_step_en),
      .cfg_mbee                     (cfg_mbee),
      .ifu_had_fetch_vld            (fetch_vld),
      .ifu_had_fetch_pc             (fetch_pc),
      .ifu_had_inst_dbg_disable     (dbg_disable),
      .iu_had_bkpt_ack              (ack),
      .iu_had_retire_vld            (retire),
      .had_core_dbg_mode_req        (core_req),
      .had_ifu_inst_bkpt_dbq_req    (dbq_req),
      .had_ifu_inst_bkpt_dbqexp_req (dbqexp_req),
      .had_yy_xx_dp_index_mbee      (mbee),
      .had_dbg_mode                 (dbg_mode),
      .had_bkpt_hit_vld             (hit_vld),
      .had_bkpt_hit_idx             (hit_idx)
   );

   assign outs = {core_req, dbq_req, dbqexp_req, dbg_mode, hit_vld, hit_idx};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic idx, input logic [31:0] pc, input logic en, input logic exp);
      cfg_wr_vld  = 1'b1;
      cfg_wr_idx  = idx;
      cfg_wr_addr = pc[31:1];
      cfg_wr_en   = en;
      cfg_wr_exp  = exp;
      step();
      cfg_wr_vld  = 1'b0;
   endtask

   task automatic test_reset();
      cpurst = 1'b1;
      cfg_mbee = 1'b1;
      step(); step();
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL reset_outs: got %b expected %b", outs, 6'b000000); end
      vectors++; if (mbee !== 1'b0) begin miscompares++; $display("FAIL reset_mbee: got %b expected %b", mbee, 1'b0); end
      cpurst = 1'b0;
      step();
      vectors++; if (mbee !== 1'b1) begin miscompares++; $display("FAIL mbee_copy: got %b expected %b", mbee, 1'b1); end
      cfg_mbee = 1'b0;
   endtask

   task automatic test_single_match();
      cfg_write(1'b0, 32'h80, 1'b1, 1'b0);
      fetch_vld = 1'b1; fetch_pc = 32'h80; dbg_disable = 1'b1;
      step();
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL dbg_disable: got %b expected %b", outs, 6'b000000); end
      dbg_disable = 1'b0;
      step();
      fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b010010) begin miscompares++; $display("FAIL t1_req: got %b expected %b", outs, 6'b010010); end
      step(); step();
      vectors++; if (outs !== 6'b010010) begin miscompares++; $display("FAIL t1_hold: got %b expected %b", outs, 6'b010010); end
      ack = 1'b1;
      step();
      ack = 1'b0;
      vectors++; if (outs !== 6'b000110) begin miscompares++; $display("FAIL t1_debug: got %b expected %b", outs, 6'b000110); end
      dbg_resume_req = 1'b1;
      step();
      dbg_resume_req = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL t1_resume: got %b expected %b", outs, 6'b000000); end
   endtask

   task automatic test_no_bypass();
      cfg_wr_vld = 1'b1; cfg_wr_idx = 1'b1; cfg_wr_addr = 31'h180; cfg_wr_en = 1'b1; cfg_wr_exp = 1'b0;
      fetch_vld = 1'b1; fetch_pc = 32'h300;
      step();
      cfg_wr_vld = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL no_bypass: got %b expected %b", outs, 6'b000000); end
      step();
      fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b010011) begin miscompares++; $display("FAIL cmp1_req: got %b expected %b", outs, 6'b010011); end
      ack = 1'b1; step(); ack = 1'b0;
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
      vectors++; if (outs !== 6'b000001) begin miscompares++; $display("FAIL cmp1_resume: got %b expected %b", outs, 6'b000001); end
   endtask

   task automatic test_priority();
      cfg_write(1'b0, 32'h100, 1'b1, 1'b0);
      cfg_write(1'b1, 32'h100, 1'b1, 1'b1);
      fetch_vld = 1'b1; fetch_pc = 32'h100;
      step();
      fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b010010) begin miscompares++; $display("FAIL prio_req: got %b expected %b", outs, 6'b010010); end
      ack = 1'b1; step(); ack = 1'b0;
      vectors++; if (outs !== 6'b000110) begin miscompares++; $display("FAIL prio_debug: got %b expected %b", outs, 6'b000110); end
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
      cfg_write(1'b0, 32'h100, 1'b0, 1'b0);
      fetch_vld = 1'b1;
      step();
      fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b001011) begin miscompares++; $display("FAIL exp_req: got %b expected %b", outs, 6'b001011); end
      ack = 1'b1; step(); ack = 1'b0;
      vectors++; if (outs !== 6'b000011) begin miscompares++; $display("FAIL exp_idle: got %b expected %b", outs, 6'b000011); end
   endtask

   task automatic test_halt_vs_match();
      cpurst = 1'b1; step(); cpurst = 1'b0;
      cfg_write(1'b0, 32'h80, 1'b1, 1'b0);
      dbg_halt_req = 1'b1; fetch_vld = 1'b1; fetch_pc = 32'h80;
      step();
      dbg_halt_req = 1'b0; fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b100000) begin miscompares++; $display("FAIL halt_wins: got %b expected %b", outs, 6'b100000); end
      step();
      vectors++; if (outs !== 6'b100000) begin miscompares++; $display("FAIL halt_hold: got %b expected %b", outs, 6'b100000); end
      ack = 1'b1; step(); ack = 1'b0;
      dbg_halt_req = 1'b1; step(); dbg_halt_req = 1'b0;
      vectors++; if (outs !== 6'b000100) begin miscompares++; $display("FAIL halt_in_debug: got %b expected %b", outs, 6'b000100); end
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL halt_resume: got %b expected %b", outs, 6'b000000); end
   endtask

   task automatic test_step();
      dbg_halt_req = 1'b1; step(); dbg_halt_req = 1'b0;
      ack = 1'b1; step(); ack = 1'b0;
      cfg_step_en = 1'b1;
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL step_enter: got %b expected %b", outs, 6'b000000); end
      fetch_vld = 1'b1; fetch_pc = 32'h80; dbg_resume_req = 1'b1;
      step();
      fetch_vld = 1'b0; dbg_resume_req = 1'b0;
      step();
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL step_wait: got %b expected %b", outs, 6'b000000); end
      retire = 1'b1; step(); retire = 1'b0;
      vectors++; if (outs !== 6'b100000) begin miscompares++; $display("FAIL step_halt: got %b expected %b", outs, 6'b100000); end
      ack = 1'b1; step(); ack = 1'b0;
      vectors++; if (outs !== 6'b000100) begin miscompares++; $display("FAIL step_debug: got %b expected %b", outs, 6'b000100); end
      cfg_step_en = 1'b0;
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
   endtask

   task automatic test_reset_mid_request();
      cfg_write(1'b0, 32'h40, 1'b1, 1'b1);
      cfg_mbee = 1'b1;
      fetch_vld = 1'b1; fetch_pc = 32'h40;
      step();
      fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b001010) begin miscompares++; $display("FAIL rst_pre: got %b expected %b", outs, 6'b001010); end
      cpurst = 1'b1; step(); cpurst = 1'b0;
      vectors++; if ({outs, mbee} !== 7'b0000000) begin miscompares++; $display("FAIL rst_mid: got %b expected %b", {outs, mbee}, 7'b0000000); end
      cfg_mbee = 1'b0;
      fetch_vld = 1'b1; step(); fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL rst_cfg_gone: got %b expected %b", outs, 6'b000000); end
   endtask

`ifdef HAD_BKPT_MASK_EN
   task automatic test_mask();
      cfg_wr_mask = 31'h7;
      cfg_write(1'b0, 32'h200, 1'b1, 1'b0);
      cfg_wr_mask = '0;
      fetch_vld = 1'b1; fetch_pc = 32'h20E; step(); fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b010010) begin miscompares++; $display("FAIL mask_hit: got %b expected %b", outs, 6'b010010); end
      ack = 1'b1; step(); ack = 1'b0;
      dbg_resume_req = 1'b1; step(); dbg_resume_req = 1'b0;
      fetch_vld = 1'b1; fetch_pc = 32'h210; step(); fetch_vld = 1'b0;
      vectors++; if (outs !== 6'b000000) begin miscompares++; $display("FAIL mask_miss: got %b expected %b", outs, 6'b000000); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_match();
      test_no_bypass();
      test_priority();
      test_halt_vs_match();
      test_step();
      test_reset_mid_request();
`ifdef HAD_BKPT_MASK_EN
      test_mask();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
